// File: rtl/stage_if_fetch_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and instruction memory (slave).
interface stage_if_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32
) ();
    logic                  imem_req_valid;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_resp_valid;
    logic [INST_WIDTH-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/stage_if_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, buffers words for ID.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module stage_if_fetch #(
    parameter int unsigned           INST_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           FIFO_DEPTH      = 4,
    parameter int unsigned           MAX_OUTSTANDING = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    stage_if_fetch_if.master      imem,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  stall_i,
    output logic [INST_WIDTH-1:0] instruction_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched_o,
    output logic [31:0]           perf_dropped_o,
    output logic [31:0]           perf_redirects_o
`endif
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OW = ((CW > IW) ? CW : IW) + 1;
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [IW-1:0]         inflight_q, inflight_d;
    logic [IW-1:0]         drop_q, drop_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]         tag_rd_q, tag_rd_d;
    logic [TW-1:0]         tag_wr_q, tag_wr_d;

    logic [INST_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] tag_q       [MAX_OUTSTANDING];

    logic [OW-1:0] occupancy;
    logic          credit;
    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    // Words already buffered plus words still coming back, minus those destined for the bin.
    assign occupancy = OW'(count_q) + OW'(inflight_q) - OW'(drop_q);
    assign credit    = (occupancy < OW'(FIFO_DEPTH)) && (inflight_q < IW'(MAX_OUTSTANDING));

    assign imem.imem_req_valid = credit && !redirect_valid_i && !rst;
    assign imem.imem_req_addr  = pc_q;

    assign req_fire  = imem.imem_req_valid && imem.imem_req_ready;
    assign resp_fire = imem.imem_resp_valid && (inflight_q != '0);
    assign push      = resp_fire && !redirect_valid_i && (drop_q == '0);
    assign pop       = inst_valid_o && !stall_i && !redirect_valid_i;

    assign inst_valid_o  = (count_q != '0) && !rst;
    assign instruction_o = inst_valid_o ? fifo_data_q[rd_ptr_q] : NOP;
    assign inst_pc_o     = inst_valid_o ? fifo_pc_q[rd_ptr_q] : '0;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + IW'(req_fire) - IW'(resp_fire);
        drop_d     = drop_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        tag_wr_d   = req_fire  ? tag_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d   = resp_fire ? tag_inc(tag_rd_q) : tag_rd_q;

        if (req_fire) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
        end
        if (resp_fire && (drop_q != '0)) begin
            drop_d = drop_q - IW'(1);
        end

        if (redirect_valid_i) begin
            pc_d     = redirect_pc_i & ~ADDR_WIDTH'(3);
            drop_d   = inflight_q - IW'(resp_fire);
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // Storage needs no reset: the counters and pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= imem.imem_resp_data;
            fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
        end
        if (req_fire) begin
            tag_q[tag_wr_q] <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_dropped_q;
    logic [31:0] perf_redirects_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q   <= '0;
            perf_dropped_q   <= '0;
            perf_redirects_q <= '0;
        end else begin
            if (push && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (resp_fire && !push && (perf_dropped_q != '1)) begin
                perf_dropped_q <= perf_dropped_q + 32'd1;
            end
            if (redirect_valid_i && (perf_redirects_q != '1)) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
        end
    end

    assign perf_fetched_o   = perf_fetched_q;
    assign perf_dropped_o   = perf_dropped_q;
    assign perf_redirects_o = perf_redirects_q;
`endif
endmodule

// File: tb/tb_stage_if_fetch.sv
// Directed bench for stage_if_fetch with an in-order, latency-1 imem model whose
// responses can be held back to build up outstanding requests.
module tb_stage_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_valid;
    bit          resp_en;
    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] pend [$];

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_dropped, perf_redirects;
`endif

    stage_if_fetch_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) imem_bus ();

    stage_if_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .imem             (imem_bus),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .stall_i          (stall),
        .instruction_o    (instruction),
        .inst_pc_o        (inst_pc),
        .inst_valid_o     (inst_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched_o   (perf_fetched),
        .perf_dropped_o   (perf_dropped),
        .perf_redirects_o (perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model: accepts on handshake, presents the oldest pending word from the next cycle.
    initial begin
        imem_bus.imem_resp_valid = 1'b0;
        imem_bus.imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                pend.delete();
            end else begin
                if (imem_bus.imem_resp_valid && pend.size() > 0) void'(pend.pop_front());
                if (imem_bus.imem_req_valid && imem_bus.imem_req_ready)
                    pend.push_back(imem_bus.imem_req_addr);
            end
            #2;
            if (resp_en && pend.size() > 0) begin
                imem_bus.imem_resp_valid = 1'b1;
                imem_bus.imem_resp_data  = mem_word(pend[0]);
            end else begin
                imem_bus.imem_resp_valid = 1'b0;
                imem_bus.imem_resp_data  = '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst                     = 1'b1;
        redirect_valid          = 1'b0;
        redirect_pc             = '0;
        stall                   = 1'b0;
        resp_en                 = 1'b1;
        imem_bus.imem_req_ready = 1'b1;

        // Reset values
        step(); step(); mid();
        chk("rst_req_valid", imem_bus.imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_instruction", instruction, 32'h13);
        chk("rst_inst_pc", inst_pc, 0);
        step(); rst = 1'b0;

        // Streaming: back-to-back issue, word visible two cycles after first request
        mid(); chk("t1_c0_valid", imem_bus.imem_req_valid, 1); chk("t1_c0_addr", imem_bus.imem_req_addr, 0);
        chk("t1_c0_inst_valid", inst_valid, 0);
        step(); mid(); chk("t1_c1_addr", imem_bus.imem_req_addr, 4); chk("t1_c1_inst_valid", inst_valid, 0);
        step(); mid(); chk("t1_c2_addr", imem_bus.imem_req_addr, 8); chk("t1_c2_inst_valid", inst_valid, 1);
        chk("t1_c2_pc", inst_pc, 0); chk("t1_c2_instr", instruction, mem_word(0));
        step(); mid(); chk("t1_c3_pc", inst_pc, 4);
        step(); mid(); chk("t1_c4_pc", inst_pc, 8); chk("t1_c4_instr", instruction, mem_word(8));
        step();

        // Stall: exactly FIFO_DEPTH words buffered, head held
        stall = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mid();
            if (i >= 2) chk("t2_head_pc", inst_pc, 0);
            if (i >= 5) chk("t2_req_off", imem_bus.imem_req_valid, 0);
            step();
        end
        stall = 1'b0;
        mid(); chk("t2_c10_pc", inst_pc, 0); chk("t2_c10_req", imem_bus.imem_req_valid, 0);
        step(); mid(); chk("t2_c11_pc", inst_pc, 4); chk("t2_c11_req", imem_bus.imem_req_valid, 1);
        chk("t2_c11_addr", imem_bus.imem_req_addr, 16);
        step(); mid(); chk("t2_c12_pc", inst_pc, 8);
        step(); mid(); chk("t2_c13_pc", inst_pc, 12);
        step(); mid(); chk("t2_c14_pc", inst_pc, 16);
        step();

        // Redirect with 3 in flight: three stale responses dropped
        resp_en = 1'b0;
        do_reset();
        step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        mid(); chk("t3_redir_req", imem_bus.imem_req_valid, 0);
        step(); redirect_valid = 1'b0; resp_en = 1'b1;
        mid(); chk("t3_c4_addr", imem_bus.imem_req_addr, 32'h100); chk("t3_c4_req", imem_bus.imem_req_valid, 1);
        chk("t3_c4_iv", inst_valid, 0);
        step(); mid(); chk("t3_c5_addr", imem_bus.imem_req_addr, 32'h104); chk("t3_c5_iv", inst_valid, 0);
        step(); mid(); chk("t3_c6_iv", inst_valid, 0);
        step(); mid(); chk("t3_c7_iv", inst_valid, 0);
        step(); mid(); chk("t3_c8_iv", inst_valid, 1); chk("t3_c8_pc", inst_pc, 32'h100);
        chk("t3_c8_instr", instruction, mem_word(32'h100));
        step();

        // Redirect coincident with a response, 2 in flight: only one more dropped
        resp_en = 1'b0;
        do_reset();
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; resp_en = 1'b1;
        mid(); chk("t4_redir_req", imem_bus.imem_req_valid, 0);
        step(); redirect_valid = 1'b0;
        mid(); chk("t4_c3_addr", imem_bus.imem_req_addr, 32'h200); chk("t4_c3_iv", inst_valid, 0);
        step(); mid(); chk("t4_c4_iv", inst_valid, 0);
        step(); mid(); chk("t4_c5_iv", inst_valid, 1); chk("t4_c5_pc", inst_pc, 32'h200);
        chk("t4_c5_instr", instruction, mem_word(32'h200));
        step();

        // imem not ready: request held stable, nothing buffered
        imem_bus.imem_req_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("t5_req_hold", imem_bus.imem_req_valid, 1);
            chk("t5_addr_hold", imem_bus.imem_req_addr, 0);
            chk("t5_iv", inst_valid, 0);
            step();
        end
        imem_bus.imem_req_ready = 1'b1;
        mid(); chk("t5_c5_addr", imem_bus.imem_req_addr, 0);
        step(); mid(); chk("t5_c6_addr", imem_bus.imem_req_addr, 4); chk("t5_c6_iv", inst_valid, 0);
        step(); mid(); chk("t5_c7_iv", inst_valid, 1); chk("t5_c7_pc", inst_pc, 0);
        step();

        // PC wrap, then reset mid-stream
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        mid(); chk("t6_redir_req", imem_bus.imem_req_valid, 0);
        step(); redirect_valid = 1'b0;
        mid(); chk("t6_c1_addr", imem_bus.imem_req_addr, 32'hFFFF_FFFC);
        step(); mid(); chk("t6_c2_addr", imem_bus.imem_req_addr, 0);
        step(); mid(); chk("t6_c3_pc", inst_pc, 32'hFFFF_FFFC); chk("t6_c3_addr", imem_bus.imem_req_addr, 4);
        step(); mid(); chk("t6_c4_pc", inst_pc, 0);
        step(); rst = 1'b1;
        mid(); chk("t6_rst_req", imem_bus.imem_req_valid, 0); chk("t6_rst_iv", inst_valid, 0);
        step(); rst = 1'b0;
        mid(); chk("t6_post_iv", inst_valid, 0); chk("t6_post_instr", instruction, 32'h13);
        chk("t6_post_pc", inst_pc, 0); chk("t6_post_req", imem_bus.imem_req_valid, 1);
        chk("t6_post_addr", imem_bus.imem_req_addr, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
